// File: rtl/camera_threshold_pkg.sv
// Shared types and defaults for the camera pixel-thresholding stage.
// Config bounds are stored zero-extended to MaxPixelWidth so one struct serves any PIXEL_WIDTH.
package camera_threshold_pkg;

    localparam int unsigned MaxPixelWidth = 16;
    localparam logic [7:0]  DefaultLo     = 8'h91;
    localparam logic [7:0]  DefaultHi     = 8'hF0;

    typedef struct packed {
        logic [MaxPixelWidth-1:0] lo;
        logic [MaxPixelWidth-1:0] hi;
        logic                     invert;
    } thresh_cfg_t;

    typedef enum logic [0:0] {
        CFG_IDLE,
        CFG_PENDING
    } cfg_state_t;

endpackage

// File: rtl/threshold_cfg_shadow.sv
// Double-buffered threshold config: a pending write becomes active on the next valid sof.
// cfg_o is the config that governs the current pixel, including the sof pixel that applies it.
module threshold_cfg_shadow
    import camera_threshold_pkg::*;
#(
    parameter int unsigned             PIXEL_WIDTH = 8,
    parameter logic [PIXEL_WIDTH-1:0]  DEFAULT_LO  = DefaultLo,
    parameter logic [PIXEL_WIDTH-1:0]  DEFAULT_HI  = DefaultHi
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        sof_i,
    input  logic        cfg_valid_i,
    input  thresh_cfg_t cfg_i,
    output thresh_cfg_t cfg_o,
    output logic        cfg_pending_o
);

    localparam thresh_cfg_t DefaultCfg = '{
        lo:     MaxPixelWidth'(DEFAULT_LO),
        hi:     MaxPixelWidth'(DEFAULT_HI),
        invert: 1'b0
    };

    cfg_state_t  state_q, state_d;
    thresh_cfg_t pend_q, pend_d;
    thresh_cfg_t act_q, act_d;
    logic        apply;

    assign apply = (state_q == CFG_PENDING) && valid_i && sof_i;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        act_d   = act_q;
        case (state_q)
            CFG_IDLE: begin
                if (cfg_valid_i) begin
                    pend_d  = cfg_i;
                    state_d = CFG_PENDING;
                end
            end
            CFG_PENDING: begin
                if (apply) begin
                    act_d   = pend_q;
                    state_d = CFG_IDLE;
                end
                // A write landing with the applying sof re-arms for the following frame.
                if (cfg_valid_i) begin
                    pend_d  = cfg_i;
                    state_d = CFG_PENDING;
                end
            end
            default: state_d = CFG_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= CFG_IDLE;
            pend_q  <= DefaultCfg;
            act_q   <= DefaultCfg;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
        end
    end

    assign cfg_o         = apply ? pend_q : act_q;
    assign cfg_pending_o = (state_q == CFG_PENDING);

endmodule

// File: rtl/threshold_mask_stream.sv
// Window/invert pixel thresholder with a registered 1-bit mask and per-frame masked-pixel count.
// PIXEL_WIDTH must not exceed camera_threshold_pkg::MaxPixelWidth.
module threshold_mask_stream
    import camera_threshold_pkg::*;
#(
    parameter int unsigned             PIXEL_WIDTH = 8,
    parameter int unsigned             COUNT_WIDTH = 20,
    parameter logic [PIXEL_WIDTH-1:0]  DEFAULT_LO  = DefaultLo,
    parameter logic [PIXEL_WIDTH-1:0]  DEFAULT_HI  = DefaultHi
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   valid_in,
    input  logic [PIXEL_WIDTH-1:0] pixel_in,
    input  logic                   sof_in,
    input  logic                   cfg_valid_in,
    input  logic [PIXEL_WIDTH-1:0] cfg_lo_in,
    input  logic [PIXEL_WIDTH-1:0] cfg_hi_in,
    input  logic                   cfg_invert_in,
    output logic                   cfg_pending_out,
    output logic                   valid_out,
    output logic                   mask_out,
    output logic [COUNT_WIDTH-1:0] count_out,
    output logic                   count_valid_out
);

    thresh_cfg_t              cfg_new;
    thresh_cfg_t              cfg_cur;
    logic [MaxPixelWidth-1:0] pix_ext;
    logic                     mask;
    logic                     sof_valid;

    logic                   valid_q, mask_q;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   count_valid_q, count_valid_d;
    logic                   seen_q, seen_d;

    assign cfg_new = '{
        lo:     MaxPixelWidth'(cfg_lo_in),
        hi:     MaxPixelWidth'(cfg_hi_in),
        invert: cfg_invert_in
    };

    threshold_cfg_shadow #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .DEFAULT_LO  (DEFAULT_LO),
        .DEFAULT_HI  (DEFAULT_HI)
    ) u_cfg_shadow (
        .clk_i         (clk_in),
        .rst_i         (rst_in),
        .valid_i       (valid_in),
        .sof_i         (sof_in),
        .cfg_valid_i   (cfg_valid_in),
        .cfg_i         (cfg_new),
        .cfg_o         (cfg_cur),
        .cfg_pending_o (cfg_pending_out)
    );

    assign pix_ext   = MaxPixelWidth'(pixel_in);
    assign mask      = ((cfg_cur.lo <= pix_ext) && (pix_ext <= cfg_cur.hi)) ^ cfg_cur.invert;
    assign sof_valid = valid_in && sof_in;

    always_comb begin
        cnt_d         = cnt_q;
        count_d       = count_q;
        count_valid_d = 1'b0;
        seen_d        = seen_q;
        if (sof_valid) begin
            // The sof pixel opens the new frame; the old frame is complete in cnt_q.
            count_d       = cnt_q;
            count_valid_d = seen_q;
            seen_d        = 1'b1;
            cnt_d         = COUNT_WIDTH'(mask);
        end else if (valid_in && mask && !(&cnt_q)) begin
            cnt_d = cnt_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q       <= 1'b0;
            mask_q        <= 1'b0;
            cnt_q         <= '0;
            count_q       <= '0;
            count_valid_q <= 1'b0;
            seen_q        <= 1'b0;
        end else begin
            valid_q       <= valid_in;
            mask_q        <= valid_in && mask;
            cnt_q         <= cnt_d;
            count_q       <= count_d;
            count_valid_q <= count_valid_d;
            seen_q        <= seen_d;
        end
    end

    assign valid_out       = valid_q;
    assign mask_out        = mask_q;
    assign count_out       = count_q;
    assign count_valid_out = count_valid_q;

endmodule

// File: tb/tb_threshold_mask_stream.sv
// Directed bench for threshold_mask_stream: frame-level reference model plus literal checks.
module tb_threshold_mask_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    logic [7:0] pixel_in = 8'h00;
    logic       sof_in = 1'b0;
    logic       cfg_valid_in = 1'b0;
    logic [7:0] cfg_lo_in = 8'h00;
    logic [7:0] cfg_hi_in = 8'h00;
    logic       cfg_invert_in = 1'b0;

    logic        pend_o, valid_o, mask_o, cv_o;
    logic [19:0] count_o;
    logic        pend4_o, valid4_o, mask4_o, cv4_o;
    logic [3:0]  count4_o;

    threshold_mask_stream #(
        .PIXEL_WIDTH (8),
        .COUNT_WIDTH (20),
        .DEFAULT_LO  (8'h91),
        .DEFAULT_HI  (8'hF0)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .valid_in        (valid_in),
        .pixel_in        (pixel_in),
        .sof_in          (sof_in),
        .cfg_valid_in    (cfg_valid_in),
        .cfg_lo_in       (cfg_lo_in),
        .cfg_hi_in       (cfg_hi_in),
        .cfg_invert_in   (cfg_invert_in),
        .cfg_pending_out (pend_o),
        .valid_out       (valid_o),
        .mask_out        (mask_o),
        .count_out       (count_o),
        .count_valid_out (cv_o)
    );

    threshold_mask_stream #(
        .PIXEL_WIDTH (8),
        .COUNT_WIDTH (4),
        .DEFAULT_LO  (8'h91),
        .DEFAULT_HI  (8'hF0)
    ) dut4 (
        .clk_in          (clk),
        .rst_in          (rst),
        .valid_in        (valid_in),
        .pixel_in        (pixel_in),
        .sof_in          (sof_in),
        .cfg_valid_in    (cfg_valid_in),
        .cfg_lo_in       (cfg_lo_in),
        .cfg_hi_in       (cfg_hi_in),
        .cfg_invert_in   (cfg_invert_in),
        .cfg_pending_out (pend4_o),
        .valid_out       (valid4_o),
        .mask_out        (mask4_o),
        .count_out       (count4_o),
        .count_valid_out (cv4_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model state: active/pending config and per-frame tallies.
    int m_lo, m_hi, p_lo, p_hi;
    bit m_inv, p_inv, m_pend, m_first;
    int m_cnt, m_cnt4, m_out, m_out4;

    // Expected outputs for the current cycle.
    bit e_valid, e_mask, e_cv, e_pend;
    int e_count, e_count4;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_lo = 'h91; m_hi = 'hF0; m_inv = 0;
        p_lo = 'h91; p_hi = 'hF0; p_inv = 0;
        m_pend = 0; m_first = 0;
        m_cnt = 0; m_cnt4 = 0; m_out = 0; m_out4 = 0;
        e_valid = 0; e_mask = 0; e_cv = 0; e_pend = 0; e_count = 0; e_count4 = 0;
    endtask

    task automatic step(input bit v, input int pix, input bit sof,
                        input bit cv, input int lo, input int hi, input bit inv);
        int  use_lo, use_hi;
        bit  use_inv, in_win, msk, pulse;
        valid_in = v; pixel_in = pix[7:0]; sof_in = sof;
        cfg_valid_in = cv; cfg_lo_in = lo[7:0]; cfg_hi_in = hi[7:0]; cfg_invert_in = inv;

        use_lo = m_lo; use_hi = m_hi; use_inv = m_inv;
        if (v && sof && m_pend) begin
            use_lo = p_lo; use_hi = p_hi; use_inv = p_inv;
        end
        in_win = (use_lo <= pix) && (pix <= use_hi);
        msk    = v && (in_win != use_inv);
        pulse  = 0;
        if (v && sof) begin
            pulse  = m_first;
            m_out  = m_cnt;
            m_out4 = m_cnt4;
            m_first = 1;
            m_cnt  = msk;
            m_cnt4 = msk;
        end else if (msk) begin
            m_cnt  = (m_cnt  < 20'hFFFFF) ? m_cnt + 1  : m_cnt;
            m_cnt4 = (m_cnt4 < 15)        ? m_cnt4 + 1 : m_cnt4;
        end
        if (v && sof && m_pend) begin
            m_lo = p_lo; m_hi = p_hi; m_inv = p_inv; m_pend = 0;
        end
        if (cv) begin
            p_lo = lo; p_hi = hi; p_inv = inv; m_pend = 1;
        end

        @(posedge clk);
        #1;
        e_valid = v; e_mask = msk; e_cv = pulse; e_pend = m_pend;
        e_count = m_out; e_count4 = m_out4;
    endtask

    task automatic px(input int pix, input bit sof);
        step(1, pix, sof, 0, 0, 0, 0);
    endtask

    task automatic wr(input int lo, input int hi, input bit inv);
        step(0, 0, 0, 1, lo, hi, inv);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("valid_out", {31'd0, valid_o}, {31'd0, e_valid});
            cmp("mask_out", {31'd0, mask_o}, {31'd0, e_mask});
            cmp("count_valid_out", {31'd0, cv_o}, {31'd0, e_cv});
            cmp("cfg_pending_out", {31'd0, pend_o}, {31'd0, e_pend});
            cmp("count_out", {12'd0, count_o}, e_count);
            cmp("count_out_w4", {28'd0, count4_o}, e_count4);
            cmp("count_valid_out_w4", {31'd0, cv4_o}, {31'd0, e_cv});
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        cmp("rst_valid", {31'd0, valid_o}, 0);
        cmp("rst_mask", {31'd0, mask_o}, 0);
        cmp("rst_count", {12'd0, count_o}, 0);
        cmp("rst_cv", {31'd0, cv_o}, 0);
        cmp("rst_pend", {31'd0, pend_o}, 0);
        rst = 1'b0;
        chk_en = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0);

        // Default window 0x91..0xF0, inclusive at both ends.
        px('h90, 0); cmp("lit_p90", {31'd0, mask_o}, 0);
        px('h91, 0); cmp("lit_p91", {31'd0, mask_o}, 1);
        px('hF0, 0); cmp("lit_pF0", {31'd0, mask_o}, 1);
        px('hF1, 0); cmp("lit_pF1", {31'd0, mask_o}, 0);
        cmp("lit_valid", {31'd0, valid_o}, 1);
        px('hA0, 0);

        // Pending config waits for sof; the pre-first-sof frame is discarded.
        wr('h10, 'h20, 0);  cmp("lit_pend_rise", {31'd0, pend_o}, 1);
        px('h15, 0);        cmp("lit_pre_sof", {31'd0, mask_o}, 0);
        px('h15, 1);        cmp("lit_sof_new_cfg", {31'd0, mask_o}, 1);
        cmp("lit_pend_fall", {31'd0, pend_o}, 0);
        cmp("lit_first_sof_no_cv", {31'd0, cv_o}, 0);

        // Frame B: 5 masked pixels including its sof pixel.
        px('h10, 0); px('h30, 0); step(0, 0, 0, 0, 0, 0, 0);
        px('h20, 0); px('h11, 0); px('h1F, 0);
        px('h50, 1);
        cmp("lit_frameB_count", {12'd0, count_o}, 5);
        cmp("lit_frameB_cv", {31'd0, cv_o}, 1);
        cmp("lit_frameB_mask", {31'd0, mask_o}, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        cmp("lit_cv_one_cycle", {31'd0, cv_o}, 0);

        // Write coinciding with an applying sof stays pending for the next frame.
        wr('h10, 'h40, 0);
        step(1, 'h20, 1, 1, 'h30, 'h40, 0);
        cmp("lit_collide_mask", {31'd0, mask_o}, 1);
        cmp("lit_collide_pend", {31'd0, pend_o}, 1);
        px('h20, 0);  cmp("lit_old_active", {31'd0, mask_o}, 1);
        px('h20, 1);  cmp("lit_second_apply", {31'd0, mask_o}, 0);
        cmp("lit_second_pend", {31'd0, pend_o}, 0);

        // Empty window: inverted masks everything, plain masks nothing.
        wr('h80, 'h40, 1);
        px('h00, 1); cmp("lit_empty_inv0", {31'd0, mask_o}, 1);
        px('h40, 0); px('h60, 0);
        px('h80, 0); cmp("lit_empty_inv80", {31'd0, mask_o}, 1);
        px('hFF, 0); cmp("lit_empty_invFF", {31'd0, mask_o}, 1);
        wr('h80, 'h40, 0);
        px('h00, 1); cmp("lit_empty_0", {31'd0, mask_o}, 0);
        px('h60, 0); cmp("lit_empty_60", {31'd0, mask_o}, 0);
        px('hFF, 0); cmp("lit_empty_FF", {31'd0, mask_o}, 0);

        // 20 masked pixels: full-width counter reads 20, 4-bit counter saturates at 15.
        wr('h00, 'hFF, 0);
        px('h33, 1);
        for (int i = 0; i < 19; i++) px(i * 13, 0);
        px('h44, 1);
        cmp("lit_sat_count20", {12'd0, count_o}, 20);
        cmp("lit_sat_count4", {28'd0, count4_o}, 15);
        px('h01, 0); px('h02, 0);

        // Asynchronous reset mid-frame with a pending config.
        wr('h00, 'h10, 0);
        px('h95, 0); px('h96, 0);
        chk_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        cmp("async_valid", {31'd0, valid_o}, 0);
        cmp("async_mask", {31'd0, mask_o}, 0);
        cmp("async_count", {12'd0, count_o}, 0);
        cmp("async_count4", {28'd0, count4_o}, 0);
        cmp("async_cv", {31'd0, cv_o}, 0);
        cmp("async_pend", {31'd0, pend_o}, 0);
        valid_in = 1'b0; sof_in = 1'b0; cfg_valid_in = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        chk_en = 1'b1;
        px('h91, 0); cmp("post_rst_91", {31'd0, mask_o}, 1);
        px('h90, 0); cmp("post_rst_90", {31'd0, mask_o}, 0);
        px('h05, 1); cmp("post_rst_default_kept", {31'd0, mask_o}, 0);
        cmp("post_rst_no_cv", {31'd0, cv_o}, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
